// File: rtl/lane_clk_gate_pkg.sv
// ============================================================================
// Module : lane_clk_gate_pkg
// Brief  : Shared state type, default constants and timer sizing for the
//          lane clock-gate controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lane_clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GATED  = 2'd2,
        ST_WAKE   = 2'd3
    } lane_gate_state_t;

    localparam int c_DEF_DRAIN_CYC   = 4;
    localparam int c_DEF_WAKE_CYC    = 2;
    localparam int c_DEF_IDLE_THRESH = 64;
    localparam int c_DEF_CNT_W       = 16;

    // Timer only needs to reach (max cycle count - 1); keep at least one bit.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_clk_gate_ctrl_gate_timer.sv
// ============================================================================
// Module : gate_timer
// Brief  : Clear/increment cycle counter with equality hit against a runtime
//          limit; shared by drain, wake settle and auto-idle timing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_timer
    import lane_clk_gate_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] r_count;

    // Saturates rather than wraps so a stalled sequence can never alias a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign hit = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/lane_clk_gate_ctrl.sv
// ============================================================================
// Module : lane_clk_gate_ctrl
// Brief  : Lane clock-enable controller: drain -> gate -> wake -> settle.
//          Optional auto-idle gating when LANE_CLK_AUTO_IDLE_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_clk_gate_ctrl
    import lane_clk_gate_pkg::*;
#(
    parameter int DRAIN_CYC   = c_DEF_DRAIN_CYC,
    parameter int WAKE_CYC    = c_DEF_WAKE_CYC,
    parameter int IDLE_THRESH = c_DEF_IDLE_THRESH,
    parameter int CNT_W       = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gateReq_i,
    input  logic             wakeReq_i,
    input  logic             laneBusy_i,
    output logic             clkEn_o,
    output logic             laneReady_o,
    output logic             gated_o,
    output logic [CNT_W-1:0] gateEvents_o
);

    localparam int c_TW = tmr_width(DRAIN_CYC, WAKE_CYC, IDLE_THRESH);
    localparam logic [c_TW-1:0] c_DRAIN_LIM = c_TW'(DRAIN_CYC - 1);
    localparam logic [c_TW-1:0] c_WAKE_LIM  = c_TW'(WAKE_CYC - 1);

    lane_gate_state_t r_state, w_next;
    logic             w_tmr_clr, w_tmr_inc, w_tmr_hit, w_idle_trip;
    logic [c_TW-1:0]  w_tmr_limit, w_act_limit;
    logic             r_clk_en, r_ready, r_gated;
    logic [CNT_W-1:0] r_events;

`ifdef LANE_CLK_AUTO_IDLE_EN
    assign w_act_limit = c_TW'(IDLE_THRESH - 1);
    assign w_idle_trip = (r_state == ST_ACTIVE) && !laneBusy_i && !wakeReq_i && w_tmr_hit;
`else
    assign w_act_limit = '0;
    assign w_idle_trip = 1'b0;
`endif

    assign w_tmr_limit = (r_state == ST_DRAIN) ? c_DRAIN_LIM :
                         (r_state == ST_WAKE)  ? c_WAKE_LIM  : w_act_limit;

    gate_timer #(.W(c_TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_tmr_clr),
        .inc   (w_tmr_inc),
        .limit (w_tmr_limit),
        .hit   (w_tmr_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_ACTIVE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_tmr_clr = 1'b1;
        w_tmr_inc = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if ((gateReq_i && !wakeReq_i) || w_idle_trip) w_next = ST_DRAIN;
`ifdef LANE_CLK_AUTO_IDLE_EN
                w_tmr_clr = laneBusy_i || wakeReq_i;
                w_tmr_inc = 1'b1;
`endif
            end
            ST_DRAIN: begin
                w_tmr_clr = laneBusy_i;
                w_tmr_inc = 1'b1;
                // Wake abort outranks drain completion in the same cycle.
                if (wakeReq_i)                     w_next = ST_ACTIVE;
                else if (!laneBusy_i && w_tmr_hit) w_next = ST_GATED;
            end
            ST_GATED: begin
                if (wakeReq_i) w_next = ST_WAKE;
            end
            ST_WAKE: begin
                w_tmr_clr = 1'b0;
                w_tmr_inc = 1'b1;
                if (w_tmr_hit) w_next = ST_ACTIVE;
            end
            default: w_next = ST_ACTIVE;
        endcase
        // Every state entry starts the shared timer from zero.
        if (w_next != r_state) w_tmr_clr = 1'b1;
    end

    // Outputs are decoded from the next state into flops: glitch-free clkEn_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_en <= 1'b1;
            r_ready  <= 1'b1;
            r_gated  <= 1'b0;
            r_events <= '0;
        end else begin
            r_clk_en <= (w_next != ST_GATED);
            r_ready  <= (w_next == ST_ACTIVE);
            r_gated  <= (w_next == ST_GATED);
            if ((w_next == ST_GATED) && (r_state != ST_GATED) && (r_events != {CNT_W{1'b1}}))
                r_events <= r_events + 1'b1;
        end
    end

    assign clkEn_o      = r_clk_en;
    assign laneReady_o  = r_ready;
    assign gated_o      = r_gated;
    assign gateEvents_o = r_events;

endmodule

`default_nettype wire

// File: tb/tb_lane_clk_gate_ctrl.sv
// ============================================================================
// Module : tb_lane_clk_gate_ctrl
// Brief  : Scoreboard bench for lane_clk_gate_ctrl: directed scenarios then
//          randomized requests, checked against a cycle-count reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_clk_gate_ctrl;

    localparam int DRAIN_CYC   = 4;
    localparam int WAKE_CYC    = 2;
    localparam int IDLE_THRESH = 8;
    localparam int CNT_W       = 2;
`ifdef LANE_CLK_AUTO_IDLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int M_ACTIVE = 0, M_DRAIN = 1, M_GATED = 2, M_WAKE = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             gateReq = 1'b0, wakeReq = 1'b0, laneBusy = 1'b0;
    logic             clkEn, laneReady, gated;
    logic [CNT_W-1:0] gateEvents;

    always #5 clk = ~clk;

    lane_clk_gate_ctrl #(
        .DRAIN_CYC   (DRAIN_CYC),
        .WAKE_CYC    (WAKE_CYC),
        .IDLE_THRESH (IDLE_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .gateReq_i    (gateReq),
        .wakeReq_i    (wakeReq),
        .laneBusy_i   (laneBusy),
        .clkEn_o      (clkEn),
        .laneReady_o  (laneReady),
        .gated_o      (gated),
        .gateEvents_o (gateEvents)
    );

    typedef struct packed {
        logic             clk_en;
        logic             ready;
        logic             gated;
        logic [CNT_W-1:0] events;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode plus a count of qualifying cycles in that mode.
    int m_mode   = M_ACTIVE;
    int m_run    = 0;
    int m_events = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic model_step(input bit g, input bit w, input bit b);
        case (m_mode)
            M_ACTIVE: begin
                if (w) m_run = 0;
                else if (g) begin m_mode = M_DRAIN; m_run = 0; end
                else if (AUTO && !b) begin
                    m_run++;
                    if (m_run == IDLE_THRESH) begin m_mode = M_DRAIN; m_run = 0; end
                end
                else m_run = 0;
            end
            M_DRAIN: begin
                if (w) begin m_mode = M_ACTIVE; m_run = 0; end
                else if (b) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == DRAIN_CYC) begin
                        m_mode = M_GATED;
                        m_run  = 0;
                        if (m_events < (1 << CNT_W) - 1) m_events++;
                    end
                end
            end
            M_GATED: if (w) begin m_mode = M_WAKE; m_run = 0; end
            default: begin
                m_run++;
                if (m_run == WAKE_CYC) begin m_mode = M_ACTIVE; m_run = 0; end
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.clk_en = (m_mode != M_GATED);
        e.ready  = (m_mode == M_ACTIVE);
        e.gated  = (m_mode == M_GATED);
        e.events = CNT_W'(m_events);
        return e;
    endfunction

    task automatic apply(input bit g, input bit w, input bit b);
        gateReq  = g;
        wakeReq  = w;
        laneBusy = b;
        model_step(g, w, b);
        exp_q.push_back(model_out());
    endtask

    task automatic drive(input bit g, input bit w, input bit b);
        @(negedge clk);
        apply(g, w, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        gateReq  = 1'b0;
        wakeReq  = 1'b0;
        laneBusy = 1'b0;
        #1;
        check("rst_clkEn", 32'(clkEn), 32'd1);
        check("rst_laneReady", 32'(laneReady), 32'd1);
        check("rst_gated", 32'(gated), 32'd0);
        check("rst_gateEvents", 32'(gateEvents), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        m_mode   = M_ACTIVE;
        m_run    = 0;
        m_events = 0;
        apply(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one expected record per clock edge while out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clkEn", 32'(clkEn), 32'(e.clk_en));
                check("laneReady", 32'(laneReady), 32'(e.ready));
                check("gated", 32'(gated), 32'(e.gated));
                check("gateEvents", 32'(gateEvents), 32'(e.events));
            end
        end
    end

    initial begin
        do_reset();
        // Quiet lane: auto-idle gates it, otherwise it stays active.
        repeat (14) drive(1'b0, 1'b0, 1'b0);
        do_reset();
        // Plain gate, then ignored gate requests while gated, then wake.
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        // Busy pulse one cycle after drain entry.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (6) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        // Wake coinciding with drain completion aborts.
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b1);
        // Third and fourth gating: counter saturates at 3.
        for (int k = 0; k < 2; k++) begin
            repeat (6) drive(1'b1, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 1'b1);
            repeat (3) drive(1'b0, 1'b0, 1'b1);
        end
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        do_reset();
        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 12,
                      $urandom_range(0, 99) < 40);
            end
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lane_clk_gate_ctrl.md
# lane_clk_gate_ctrl

Clock-enable controller for one reconfigurable execution lane. It decides when the lane's clock may be stopped and restarted, and drives `clkEn_o` directly into the lane's `clk_gater_ul` instance. The controller runs on the ungated core clock and sits between the reconfiguration/power manager and the gater cell. It drains in-flight work before gating and enforces a wake-up settle time before the lane accepts work again.

## Interface
Parameters:
- `DRAIN_CYC`, default 4: consecutive idle cycles required in DRAIN before gating. Legal range ≥1.
- `WAKE_CYC`, default 2: settle cycles after the clock is re-enabled before the lane is ready. Legal range ≥1.
- `IDLE_THRESH`, default 64: consecutive idle cycles in ACTIVE that trigger auto-gating. Used only with the config macro. Legal range ≥1.
- `CNT_W`, default 16: width of the gate-event statistics counter.

Ports:
- `clk` in 1: ungated core clock.
- `reset` in 1: asynchronous, active-high reset.
- `gateReq_i` in 1: level request to power the lane down.
- `wakeReq_i` in 1: level request to power the lane up. Has priority over `gateReq_i`.
- `laneBusy_i` in 1: lane has work in flight.
- `clkEn_o` out 1: registered enable to `clk_gater_ul.clkEn_i`.
- `laneReady_o` out 1: lane may accept new work.
- `gated_o` out 1: high while in GATED.
- `gateEvents_o` out CNT_W: saturating count of entries into GATED.

## Operation
- FSM states: ACTIVE, DRAIN, GATED, WAKE.
- All outputs are registered and decoded from state, so `clkEn_o` is glitch-free.
- Reset values:
  - state = ACTIVE
  - `clkEn_o` = 1
  - `laneReady_o` = 1
  - `gated_o` = 0
  - `gateEvents_o` = 0
  - timer = 0
- ACTIVE:
  - `gateReq_i` & !`wakeReq_i` → DRAIN.
  - Otherwise stay.
- DRAIN:
  - `laneReady_o` = 0, `clkEn_o` = 1.
  - Timer cleared on entry.
  - Each cycle with `laneBusy_i`=0 the timer increments; `laneBusy_i`=1 clears it.
  - Timer == DRAIN_CYC-1 and `laneBusy_i`=0 → GATED.
  - `wakeReq_i`=1 aborts: → ACTIVE. Abort has priority over completion in the same cycle.
  - `gateReq_i` dropping does NOT abort; only `wakeReq_i` does.
- GATED:
  - `clkEn_o` = 0, `gated_o` = 1, `laneReady_o` = 0.
  - On the entering transition `gateEvents_o` increments, saturating at all-ones.
  - `wakeReq_i` → WAKE. `gateReq_i` is ignored here.
- WAKE:
  - `clkEn_o` = 1, `laneReady_o` = 0.
  - Timer counts each cycle from 0; timer == WAKE_CYC-1 → ACTIVE.
  - Requests are ignored until ACTIVE is reached. Level-held `gateReq_i` is honoured in ACTIVE afterwards.
- Reset mid-operation, in any state: immediate return to reset values. The clock is re-enabled asynchronously.

## Timing
- `gateReq_i` sampled at cycle t in ACTIVE:
  - DRAIN at t+1, `laneReady_o` low at t+1.
  - With `laneBusy_i`=0 throughout, `clkEn_o` low and `gated_o` high at t+1+DRAIN_CYC.
- A busy pulse in DRAIN delays gating by (cycles since entry before the pulse)+1.
- `wakeReq_i` sampled at cycle w in GATED:
  - `clkEn_o` high at w+1.
  - `laneReady_o` high at w+1+WAKE_CYC.
- Simultaneous `gateReq_i` and `wakeReq_i`: wake wins in every state.
- The timer is wide enough for max(DRAIN_CYC, WAKE_CYC, IDLE_THRESH) and never wraps.

## Configuration
- `LANE_CLK_AUTO_IDLE_EN` defined:
  - ACTIVE keeps an idle counter: increments when `laneBusy_i`=0 & !`wakeReq_i`, clears otherwise.
  - Reaching IDLE_THRESH-1 with the lane still idle → DRAIN, exactly as if `gateReq_i` had been asserted.
  - The counter clears on leaving ACTIVE.
- Undefined: gating occurs only via `gateReq_i`, and the idle counter logic is absent.

## Structure
- Shared package `lane_clk_gate_pkg`:
  - `lane_gate_state_t` enum (ACTIVE, DRAIN, GATED, WAKE).
  - Default parameter constants.
  - Timer-width function (clog2 of max of the three cycle parameters).
- One sub-module, `gate_timer`: clear/increment counter with a `hit` compare against a runtime limit. It is shared by DRAIN, WAKE and auto-idle.
- The parent lane wrapper instantiates `clk_gater_ul` and connects `clkEn_o`. The gater is not instantiated inside this block.

## Test plan
- Reset, then `gateReq_i`=1 at cycle 10 with busy=0, DRAIN_CYC=4 → `clkEn_o`=0 at cycle 15, `gateEvents_o`=1.
- `gateReq_i` at cycle 10, busy=1 on cycle 12 → `clkEn_o`=0 at cycle 17.
- In GATED, `wakeReq_i` at cycle 30, WAKE_CYC=2 → `clkEn_o`=1 at 31, `laneReady_o`=1 at 33.
- In DRAIN, `wakeReq_i` and completion coincide → ACTIVE next cycle, `clkEn_o` never drops, `gateEvents_o` unchanged.
- Force `gateEvents_o` to all-ones with CNT_W=2 (3 gate cycles), then gate a 4th time → stays 3.
- With `LANE_CLK_AUTO_IDLE_EN`, IDLE_THRESH=8, busy=0 from cycle 0 → DRAIN at 8, GATED at 12. Same stimulus without the macro → stays ACTIVE. Assert `reset` in GATED → `clkEn_o`=1 immediately.
